// File: rtl/stb_pkg.sv
// Shared sizes and types for the data store buffer and its match logic.
// The STB_FWD_EN build macro is consumed by data_store_buffer, not by this package.
package stb_pkg;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int WADDR_W = ADDR_W - 2;
    localparam int PTR_W   = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    typedef struct packed {
        logic [ADDR_W-3:0] waddr;
        logic [DATA_W-1:0] data;
    } stb_entry_t;

    // Owner of the single memory port in the current cycle.
    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_DRAIN,
        PORT_LOAD
    } port_sel_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/stb_match.sv
// Parallel word-address compare over all buffer slots with youngest-hit selection.
module stb_match
    import stb_pkg::*;
(
    input  logic [DEPTH*WADDR_W-1:0] entry_waddr,
    input  logic [DEPTH*DATA_W-1:0]  entry_data,
    input  logic [DEPTH-1:0]         valid,
    input  logic [PTR_W-1:0]         tail,
    input  logic [WADDR_W-1:0]       waddr,
    output logic                     hit,
    output logic [DATA_W-1:0]        hit_data
);

    logic [DEPTH-1:0]  match;
    logic [DATA_W-1:0] data_arr [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi]    = valid[gi] && (entry_waddr[gi*WADDR_W +: WADDR_W] == waddr);
            assign data_arr[gi] = entry_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Walk from the oldest possible slot up to tail-1 so the youngest match is assigned last.
    always_comb begin
        ptr_t idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - ptr_t'(k);
            if (match[idx]) begin
                hit      = 1'b1;
                hit_data = data_arr[idx];
            end
        end
    end

endmodule

// File: rtl/data_store_buffer.sv
// Posted-write store buffer between the EX/MEM register and a single-port data memory.
// Define STB_FWD_EN to forward buffered store data to loads that hit the buffer.
module data_store_buffer
    import stb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              req_ready_o,
    output logic [DATA_W-1:0] load_data_o,
    input  logic              fence_i,
    output logic              empty_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    stb_entry_t               entries_reg [DEPTH];
    logic [DEPTH-1:0]         valid_reg;
    ptr_t                     head_reg;
    ptr_t                     tail_reg;
    cnt_t                     count_reg;

    logic                     is_load;
    logic                     is_store;
    logic                     full;
    logic                     nonempty;
    logic                     fence_block;
    logic                     push;
    logic                     pop;
    logic                     hit;
    logic [DATA_W-1:0]        hit_data;
    logic [DEPTH*WADDR_W-1:0] flat_waddr;
    logic [DEPTH*DATA_W-1:0]  flat_data;
    stb_entry_t               head_entry;
    port_sel_t                port_sel;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign flat_waddr[gi*WADDR_W +: WADDR_W] = entries_reg[gi].waddr;
            assign flat_data[gi*DATA_W +: DATA_W]    = entries_reg[gi].data;
        end
    endgenerate

    stb_match u_match (
        .entry_waddr (flat_waddr),
        .entry_data  (flat_data),
        .valid       (valid_reg),
        .tail        (tail_reg),
        .waddr       (req_addr_i[ADDR_W-1:2]),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    assign is_load     = req_valid_i && !req_write_i;
    assign is_store    = req_valid_i && req_write_i;
    assign full        = (count_reg == cnt_t'(DEPTH));
    assign nonempty    = (count_reg != '0);
    assign fence_block = fence_i && nonempty;
    assign head_entry  = entries_reg[head_reg];
    assign empty_o     = !nonempty;

`ifndef STB_FWD_EN
    // Without forwarding the matched data is never consumed; a hit only forces draining.
    logic unused_hit_data;
    assign unused_hit_data = ^hit_data;
`endif

    // Port arbitration and request acceptance.
    always_comb begin
        port_sel    = PORT_IDLE;
        req_ready_o = 1'b0;
        load_data_o = '0;
        push        = 1'b0;
        if (full || fence_block) begin
            port_sel = PORT_DRAIN;
        end else if (is_load) begin
            if (!hit) begin
                port_sel    = PORT_LOAD;
                req_ready_o = 1'b1;
                load_data_o = mem_rdata_i;
            end else begin
`ifdef STB_FWD_EN
                req_ready_o = 1'b1;
                load_data_o = hit_data;
`endif
                port_sel    = PORT_DRAIN;
            end
        end else begin
            req_ready_o = 1'b1;
            push        = is_store;
            if (nonempty) begin
                port_sel = PORT_DRAIN;
            end
        end
    end

    always_comb begin
        pop         = 1'b0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (port_sel)
            PORT_DRAIN: begin
                pop         = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {head_entry.waddr, 2'b00};
                mem_wdata_o = head_entry.data;
            end
            PORT_LOAD: begin
                mem_read_o  = 1'b1;
                mem_addr_o  = req_addr_i;
            end
            default: ;
        endcase
    end

    // Reset drops any buffered stores without writing them to memory.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            if (push) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= ptr_inc(tail_reg);
            end
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= ptr_inc(head_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + cnt_t'(1);
                2'b01:   count_reg <= count_reg - cnt_t'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            entries_reg[tail_reg] <= {req_addr_i[ADDR_W-1:2], req_wdata_i};
        end
    end

endmodule

// File: tb/tb_data_store_buffer.sv
// Self-checking bench for data_store_buffer: directed scenarios plus randomized traffic
// compared against a queue-based store buffer model and a memory image.
`timescale 1ns/1ps
module tb_data_store_buffer;
    import stb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic [31:0] load_data;
    logic        fence;
    logic        empty;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    data_store_buffer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_ready_o (req_ready),
        .load_data_o (load_data),
        .fence_i     (fence),
        .empty_o     (empty),
        .mem_addr_o  (mem_addr),
        .mem_write_o (mem_write),
        .mem_read_o  (mem_read),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    typedef struct {
        logic [29:0] waddr;
        logic [31:0] data;
    } st_t;

    st_t         stb_q[$];
    logic [31:0] model_mem [64];
    logic [31:0] tb_mem [64];
    int          checks = 0;
    int          failures = 0;

    logic        exp_ready, exp_mwrite, exp_mread, exp_push, exp_pop;
    logic [31:0] exp_ld, exp_maddr, exp_wdata;

    task automatic set_inputs(input logic v, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic f);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        fence     = f;
        #1;
        mem_rdata = tb_mem[mem_addr[7:2]];
        #1;
    endtask

    // Expected port behaviour from the pending-store queue and the buffer's arbitration rules.
    task automatic predict();
        int          n;
        logic        hit, ld, st;
        logic [31:0] hdata;
        n     = stb_q.size();
        hit   = 1'b0;
        hdata = '0;
        ld    = req_valid && !req_write;
        st    = req_valid && req_write;
        for (int i = 0; i < n; i++) begin
            if (stb_q[i].waddr == req_addr[31:2]) begin
                hit   = 1'b1;
                hdata = stb_q[i].data;
            end
        end
        exp_ready = 0; exp_ld = '0; exp_mread = 0; exp_mwrite = 0;
        exp_maddr = '0; exp_wdata = '0; exp_push = 0; exp_pop = 0;
        if (n == DEPTH || (fence && n > 0)) begin
            exp_pop = 1;
        end else if (ld && hit) begin
`ifdef STB_FWD_EN
            exp_ready = 1;
            exp_ld    = hdata;
`endif
            exp_pop = 1;
        end else if (ld) begin
            exp_ready = 1;
            exp_mread = 1;
            exp_maddr = req_addr;
            exp_ld    = model_mem[req_addr[7:2]];
        end else begin
            exp_ready = 1;
            exp_push  = st;
            exp_pop   = (n > 0);
        end
        if (exp_pop) begin
            exp_mwrite = 1;
            exp_maddr  = {stb_q[0].waddr, 2'b00};
            exp_wdata  = stb_q[0].data;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        predict();
    endtask

    task automatic advance();
        logic        w, r;
        logic [31:0] a, d;
        w = mem_write; a = mem_addr; d = mem_wdata; r = rst;
        @(posedge clk);
        if (w === 1'b1) tb_mem[a[7:2]] = d;
        if (exp_pop) begin
            model_mem[stb_q[0].waddr[5:0]] = stb_q[0].data;
            void'(stb_q.pop_front());
        end
        if (!r) stb_q.delete();
        else if (exp_push) stb_q.push_back(st_t'{req_addr[31:2], req_wdata});
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_inputs(0, 0, 32'h0, 32'h0, 0);
            sample();
            advance();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_cycles(2);
        rst = 1'b1;
        set_inputs(0, 0, 32'h0, 32'h0, 0);
        sample();
        checks++;
        if ({mem_write, mem_read, mem_addr, mem_wdata} !== 66'h0) begin
            failures++;
            $display("FAIL reset_mem_port got w=%b r=%b a=%h d=%h exp all 0", mem_write, mem_read, mem_addr, mem_wdata);
        end
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++;
        if (load_data !== 32'h0) begin failures++; $display("FAIL reset_load_data got=%h exp=0", load_data); end
        advance();
    endtask

    task automatic test_single_store();
        set_inputs(1, 1, 32'h10, 32'hAAAA5555, 0);
        sample();
        checks++;
        if (req_ready !== 1'b1 || mem_write !== 1'b0) begin
            failures++; $display("FAIL store_accept got ready=%b mwrite=%b exp ready=1 mwrite=0", req_ready, mem_write);
        end
        advance();
        set_inputs(0, 0, 32'h0, 32'h0, 0);
        sample();
        checks++;
        if (mem_write !== 1'b1) begin failures++; $display("FAIL store_drain_we got=%b exp=1", mem_write); end
        checks++;
        if (mem_addr !== 32'h10) begin failures++; $display("FAIL store_drain_addr got=%h exp=00000010", mem_addr); end
        checks++;
        if (mem_wdata !== 32'hAAAA5555) begin failures++; $display("FAIL store_drain_data got=%h exp=aaaa5555", mem_wdata); end
        checks++;
        if (empty !== 1'b0) begin failures++; $display("FAIL store_not_empty got=%b exp=0", empty); end
        advance();
        set_inputs(0, 0, 32'h0, 32'h0, 0);
        sample();
        checks++;
        if (empty !== 1'b1 || mem_write !== 1'b0) begin
            failures++; $display("FAIL store_done got empty=%b mwrite=%b exp empty=1 mwrite=0", empty, mem_write);
        end
        advance();
        set_inputs(1, 0, 32'h10, 32'h0, 0);
        sample();
        checks++;
        if (load_data !== 32'hAAAA5555 || mem_read !== 1'b1) begin
            failures++; $display("FAIL store_readback got data=%h rd=%b exp data=aaaa5555 rd=1", load_data, mem_read);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [5];
        for (int i = 0; i < 5; i++) vals[i] = $urandom;
        for (int i = 0; i < 5; i++) begin
            for (int tries = 0; tries < 8; tries++) begin
                set_inputs(1, 1, 32'h40 + 32'(4*i), vals[i], 0);
                sample();
                checks++;
                if (req_ready !== exp_ready) begin
                    failures++; $display("FAIL b2b_store_ready[%0d] got=%b exp=%b", i, req_ready, exp_ready);
                end
                advance();
                if (exp_ready) break;
            end
            set_inputs(1, 0, 32'hC0 + 32'(4*i), 32'h0, 0);
            sample();
            checks++;
            if (load_data !== exp_ld || mem_read !== exp_mread || mem_write !== exp_mwrite) begin
                failures++;
                $display("FAIL b2b_load[%0d] got data=%h rd=%b wr=%b exp data=%h rd=%b wr=%b",
                         i, load_data, mem_read, mem_write, exp_ld, exp_mread, exp_mwrite);
            end
            advance();
        end
        idle_cycles(4);
        for (int i = 0; i < 5; i++) begin
            set_inputs(1, 0, 32'h40 + 32'(4*i), 32'h0, 0);
            sample();
            checks++;
            if (load_data !== vals[i]) begin
                failures++; $display("FAIL b2b_readback[%0d] got=%h exp=%h", i, load_data, vals[i]);
            end
            advance();
        end
    endtask

    task automatic test_forward();
        logic done;
        set_inputs(1, 1, 32'h20, 32'h1, 0);
        sample();
        advance();
        set_inputs(1, 1, 32'h20, 32'h2, 0);
        sample();
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL fwd_store2_ready got=%b exp=1", req_ready); end
        advance();
        set_inputs(1, 0, 32'h20, 32'h0, 0);
        sample();
`ifdef STB_FWD_EN
        checks++;
        if (req_ready !== 1'b1 || load_data !== 32'h2 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL fwd_hit got ready=%b data=%h rd=%b exp ready=1 data=00000002 rd=0", req_ready, load_data, mem_read);
        end
        advance();
`else
        checks++;
        if (req_ready !== 1'b0 || mem_write !== 1'b1) begin
            failures++; $display("FAIL hold_hit got ready=%b wr=%b exp ready=0 wr=1", req_ready, mem_write);
        end
        advance();
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            set_inputs(1, 0, 32'h20, 32'h0, 0);
            sample();
            if (req_ready === 1'b1) begin
                done = 1'b1;
                checks++;
                if (load_data !== 32'h2 || mem_read !== 1'b1) begin
                    failures++; $display("FAIL hold_release got data=%h rd=%b exp data=00000002 rd=1", load_data, mem_read);
                end
            end
            advance();
        end
        checks++;
        if (!done) begin failures++; $display("FAIL hold_timeout got ready=0 for 8 cycles exp ready=1"); end
`endif
        idle_cycles(2);
    endtask

    task automatic test_load_miss();
        logic [31:0] v;
        v = $urandom;
        set_inputs(1, 1, 32'h30, v, 0);
        sample();
        advance();
        set_inputs(1, 0, 32'h24, 32'h0, 0);
        sample();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h24 || mem_write !== 1'b0) begin
            failures++; $display("FAIL miss_port got rd=%b addr=%h wr=%b exp rd=1 addr=00000024 wr=0", mem_read, mem_addr, mem_write);
        end
        checks++;
        if (load_data !== model_mem[9] || req_ready !== 1'b1) begin
            failures++; $display("FAIL miss_data got data=%h ready=%b exp data=%h ready=1", load_data, req_ready, model_mem[9]);
        end
        checks++;
        if (empty !== 1'b0) begin failures++; $display("FAIL miss_buffered got empty=%b exp=0", empty); end
        advance();
        idle_cycles(2);
    endtask

    task automatic test_fence_and_reset();
        logic [31:0] v, old;
        v = $urandom;
        set_inputs(1, 1, 32'h50, v, 0);
        sample();
        advance();
        set_inputs(1, 0, 32'h54, 32'h0, 1);
        sample();
        checks++;
        if (req_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 32'h50) begin
            failures++; $display("FAIL fence_block got ready=%b wr=%b addr=%h exp ready=0 wr=1 addr=00000050", req_ready, mem_write, mem_addr);
        end
        advance();
        set_inputs(1, 0, 32'h54, 32'h0, 1);
        sample();
        checks++;
        if (req_ready !== 1'b1 || empty !== 1'b1 || load_data !== model_mem[21]) begin
            failures++; $display("FAIL fence_release got ready=%b empty=%b data=%h exp ready=1 empty=1 data=%h", req_ready, empty, load_data, model_mem[21]);
        end
        advance();
        old = model_mem[24];
        set_inputs(1, 1, 32'h60, 32'hDEAD0001, 0);
        sample();
        advance();
        rst = 1'b0;
        set_inputs(1, 0, 32'h64, 32'h0, 0);
        sample();
        advance();
        rst = 1'b1;
        set_inputs(0, 0, 32'h0, 32'h0, 0);
        sample();
        checks++;
        if (empty !== 1'b1 || mem_write !== 1'b0) begin
            failures++; $display("FAIL reset_discard got empty=%b wr=%b exp empty=1 wr=0", empty, mem_write);
        end
        advance();
        set_inputs(1, 0, 32'h60, 32'h0, 0);
        sample();
        checks++;
        if (load_data !== old) begin failures++; $display("FAIL reset_discard_mem got=%h exp=%h", load_data, old); end
        advance();
    endtask

    task automatic test_random();
        logic        pend, v, w, f;
        logic [31:0] a, d;
        int          op;
        pend = 0; v = 0; w = 0; a = 0; d = 0;
        for (int c = 0; c < 300; c++) begin
            if (!pend) begin
                op = $urandom_range(0, 9);
                v  = (op < 7);
                w  = (op < 4);
                a  = 32'h80 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                d  = $urandom;
            end
            f = ($urandom_range(0, 9) == 0);
            set_inputs(v, w, a, d, f);
            sample();
            checks++;
            if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_ready); end
            checks++;
            if (load_data !== exp_ld) begin failures++; $display("FAIL rnd_load_data cyc=%0d got=%h exp=%h", c, load_data, exp_ld); end
            checks++;
            if (mem_write !== exp_mwrite || mem_read !== exp_mread) begin
                failures++; $display("FAIL rnd_mem_ctl cyc=%0d got wr=%b rd=%b exp wr=%b rd=%b", c, mem_write, mem_read, exp_mwrite, exp_mread);
            end
            checks++;
            if (mem_addr !== exp_maddr || mem_wdata !== exp_wdata) begin
                failures++; $display("FAIL rnd_mem_bus cyc=%0d got a=%h d=%h exp a=%h d=%h", c, mem_addr, mem_wdata, exp_maddr, exp_wdata);
            end
            checks++;
            if (empty !== (stb_q.size() == 0)) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", c, empty, stb_q.size() == 0); end
            pend = v && !exp_ready;
            advance();
        end
        idle_cycles(DEPTH + 2);
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (tb_mem[i] !== model_mem[i]) begin
                failures++; $display("FAIL final_mem[%0d] got=%h exp=%h", i, tb_mem[i], model_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = 32'h1000_0000 + 32'(i * 257);
            tb_mem[i]    = 32'h1000_0000 + 32'(i * 257);
        end
        rst = 1'b0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; fence = 0; mem_rdata = 0;
        test_reset();
        test_single_store();
        test_back_to_back();
        test_forward();
        test_load_miss();
        test_fence_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
